riscv_fetch_unit: RTL

Instruction-fetch front end for `riscv32i_core`. Holds the fetch PC, issues word requests to instruction memory over a valid/ready channel, and buffers in-order responses in a prefetch FIFO. It delivers `{pc, instr}` pairs to the core's decode stage over a valid/ready handshake. On a redirect from the core's branch/jump logic, it flushes its buffer, discards stale in-flight responses and restarts fetch at the new target.

---
 rtl/riscv_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/riscv_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types and constants for the instruction fetch front end
//
// Contents:
//   XLEN          : architectural register / address width
//   INSTR_BYTES   : byte size of one instruction word (fetch stride)
//   fetch_entry_t : one prefetch buffer entry, {pc, instr}
package riscv_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO of fetch_entry_t with flush
//
// Ports:
//   clk        : clock, all updates on rising edge
//   reset_n    : asynchronous active-low reset, empties the FIFO and clears storage
//   push       : write push_data at the tail this cycle
//   push_data  : entry to write
//   pop        : remove the head entry this cycle (ignored when empty)
//   flush      : discard every entry; wins over push and pop
//   count      : number of valid entries (0..DEPTH)
//   empty      : count == 0
//   head       : oldest entry, read combinationally from registered storage
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          empty,
    output fetch_entry_t  head
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign head  = mem[rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle; the fetch credit scheme never asks for more than that.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch front end: PC, imem request/response, prefetch buffer
//
// Parameters:
//   RESET_PC   : first fetch address after reset
//   FIFO_DEPTH : prefetch entries (power of two, >= 2); also the cap on
//                outstanding requests + buffered entries
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      : word fetch request channel
//   imem_rsp_valid/data            : in-order responses, no backpressure
//   redirect_valid/redirect_pc     : single-cycle restart of fetch at a new target
//   instr_valid/ready, instr, pc   : {pc, instr} delivery to decode
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    localparam int              CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] RESET_WORD   = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] STRIDE       = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard_cnt;
    logic            running;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_push_data;

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_keep;
    logic            consume;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   rsp_dec;

    // The low two bits of a redirect target are dropped on purpose.
    logic            unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign rsp_dec         = CW'(imem_rsp_valid);

    // Every accepted request reserves a FIFO slot until its response is either
    // buffered and popped, or discarded; this is what keeps the FIFO from
    // overflowing without any backpressure on the response channel.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT_LIMIT;

    // running holds the request low while in reset and releases it on the
    // first clock edge after reset_n rises.
    assign imem_req_valid = running && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses landing in the redirect cycle belong to the old stream.
    assign rsp_keep = imem_rsp_valid && (discard_cnt == '0) && !redirect_valid;

    assign fifo_push_data = '{pc: rsp_pc, instr: imem_rsp_data};

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head.instr;
    assign pc          = fifo_head.pc;
    assign consume     = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_WORD;
            rsp_pc      <= RESET_WORD;
            outstanding <= '0;
            discard_cnt <= '0;
            running     <= 1'b0;
        end else begin
            running <= 1'b1;
            if (redirect_valid) begin
                // Everything still in flight (minus a response retiring right
                // now) is stale and must be dropped when it arrives.
                fetch_pc    <= redirect_target;
                rsp_pc      <= redirect_target;
                outstanding <= outstanding - rsp_dec;
                discard_cnt <= outstanding - rsp_dec;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + STRIDE;
                end
                case ({req_fire, imem_rsp_valid})
                    2'b10:   outstanding <= outstanding + CW'(1);
                    2'b01:   outstanding <= outstanding - CW'(1);
                    default: outstanding <= outstanding;
                endcase
                if (imem_rsp_valid) begin
                    if (discard_cnt != '0) begin
                        discard_cnt <= discard_cnt - CW'(1);
                    end else begin
                        rsp_pc <= rsp_pc + STRIDE;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rsp_keep),
        .push_data (fifo_push_data),
        .pop       (consume),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule
